// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, direction bits and paddle-cover helper for the Pong blocks.
package pong_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_e;

    localparam int DIR_EAST_BIT  = 0;
    localparam int DIR_NORTH_BIT = 1;
    localparam int SCORE_W       = 4;

    // Bottom row is formed 7 bits wide so a paddle near row 63 cannot wrap.
    function automatic logic covers(input logic [5:0] top, input logic [5:0] y, input int h);
        logic [6:0] bot;
        bot = {1'b0, top} + 7'(h) - 7'd1;
        return ({1'b0, y} >= {1'b0, top}) && ({1'b0, y} <= bot);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if: ball/paddle/button inputs and score/state outputs of the match sequencer.
interface pong_match_ctrl_if;
    import pong_pkg::*;
    logic               i_start;
    logic [5:0]         i_ball_x;
    logic [5:0]         i_ball_y;
    logic [1:0]         i_ball_dir;
    logic [5:0]         i_paddle_l_y;
    logic [5:0]         i_paddle_r_y;
    logic               o_ball_enable;
    logic [SCORE_W-1:0] o_score_l;
    logic [SCORE_W-1:0] o_score_r;
    logic [2:0]         o_state;
    logic               o_winner;
    logic               o_point;

    modport master (
        output i_start, i_ball_x, i_ball_y, i_ball_dir, i_paddle_l_y, i_paddle_r_y,
        input  o_ball_enable, o_score_l, o_score_r, o_state, o_winner, o_point
    );

    modport slave (
        input  i_start, i_ball_x, i_ball_y, i_ball_dir, i_paddle_l_y, i_paddle_r_y,
        output o_ball_enable, o_score_l, o_score_r, o_state, o_winner, o_point
    );
endinterface

// File: rtl/pong_tick_timer.sv
// pong_tick_timer: loadable down-counter; done is high while the count sits at zero.
module pong_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: Pong match sequencer (serve, play, miss detection, scoring, winner).
// PONG_SERVE_DELAY_EN enables the SERVE/POINT tick timer; otherwise both states last one cycle.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int GAME_WIDTH  = 40,
    parameter int GAME_HEIGHT = 30,
    parameter int PADDLE_H    = 6,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 25000000,
    parameter int POINT_TICKS = 12500000
) (
    input logic              i_clk,
    input logic              i_rst_n,
    pong_match_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'(IDLE);
    localparam logic [2:0] ST_SERVE = 3'(SERVE);
    localparam logic [2:0] ST_PLAY  = 3'(PLAY);
    localparam logic [2:0] ST_POINT = 3'(POINT);
    localparam logic [2:0] ST_OVER  = 3'(OVER);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SAT = '1;

    logic [2:0]         state, state_n;
    logic [SCORE_W-1:0] score_l, score_r, score_l_n, score_r_n;
    logic               winner, winner_n, point_n;
    logic               miss_l, miss_r, expired, won;

    assign miss_l = (bus.i_ball_x == 6'd0) && !bus.i_ball_dir[DIR_EAST_BIT]
                    && !covers(bus.i_paddle_l_y, bus.i_ball_y, PADDLE_H);
    assign miss_r = (bus.i_ball_x == 6'(GAME_WIDTH)) && bus.i_ball_dir[DIR_EAST_BIT]
                    && !covers(bus.i_paddle_r_y, bus.i_ball_y, PADDLE_H);
    assign won    = (score_l == WIN) || (score_r == WIN);

`ifdef PONG_SERVE_DELAY_EN
    localparam int CNT_W = $clog2(max_int(SERVE_TICKS, POINT_TICKS) + 1);
    logic             load;
    logic [CNT_W-1:0] load_val;

    // Reloaded on every entry into SERVE or POINT so the stay is exactly N cycles.
    assign load     = (state_n != state) && (state_n == ST_SERVE || state_n == ST_POINT);
    assign load_val = (state_n == ST_SERVE) ? CNT_W'(SERVE_TICKS - 1) : CNT_W'(POINT_TICKS - 1);

    pong_tick_timer #(.W(CNT_W)) u_timer (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .load  (load),
        .value (load_val),
        .done  (expired)
    );
`else
    assign expired = 1'b1;
`endif

    always_comb begin
        state_n   = state;
        score_l_n = score_l;
        score_r_n = score_r;
        winner_n  = winner;
        point_n   = 1'b0;
        case (state)
            ST_IDLE: if (bus.i_start) begin
                state_n   = ST_SERVE;
                score_l_n = '0;
                score_r_n = '0;
            end
            ST_SERVE: state_n = expired ? ST_PLAY : ST_SERVE;
            ST_PLAY: if (miss_l) begin
                score_r_n = (score_r == SAT) ? SAT : score_r + 1'b1;
                point_n   = 1'b1;
                state_n   = ST_POINT;
            end else if (miss_r) begin
                score_l_n = (score_l == SAT) ? SAT : score_l + 1'b1;
                point_n   = 1'b1;
                state_n   = ST_POINT;
            end
            // Only the player who just scored can have reached the winning score.
            ST_POINT: if (won) begin
                state_n  = ST_OVER;
                winner_n = (score_r == WIN);
            end else if (expired) begin
                state_n = ST_SERVE;
            end
            ST_OVER: if (bus.i_start) begin
                state_n   = ST_SERVE;
                score_l_n = '0;
                score_r_n = '0;
                winner_n  = 1'b0;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= ST_IDLE;
            score_l           <= '0;
            score_r           <= '0;
            winner            <= 1'b0;
            bus.o_point       <= 1'b0;
            bus.o_ball_enable <= 1'b0;
        end else begin
            state             <= state_n;
            score_l           <= score_l_n;
            score_r           <= score_r_n;
            winner            <= winner_n;
            bus.o_point       <= point_n;
            bus.o_ball_enable <= (state_n == ST_PLAY);
        end
    end

    assign bus.o_state   = state;
    assign bus.o_score_l = score_l;
    assign bus.o_score_r = score_r;
    assign bus.o_winner  = winner;
endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong game. It gates the ball's enable, which recentres the ball when low, and watches the ball's position and direction against both paddles. It detects misses, keeps both scores, inserts serve and point pauses, and declares a winner. It sits between the button/debounce logic and the ball, paddle and score-display blocks, all on the 25 MHz pixel-domain clock.

## Interface
- GAME_WIDTH, 40: rightmost ball column; the ball bounces at x==0 and x==GAME_WIDTH.
- GAME_HEIGHT, 30: bottom ball row.
- PADDLE_H, 6: paddle height in rows.
- WIN_SCORE, 9: score that ends the match; range 1..15.
- SERVE_TICKS, 25000000: cycles spent in SERVE before the ball is released.
- POINT_TICKS, 12500000: cycles spent in POINT after a miss.
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle debounced start pulse.
- i_ball_x  in  6  current ball column.
- i_ball_y  in  6  current ball row.
- i_ball_dir  in  2  ball direction; bit0 = 1 east, bit1 = 1 north.
- i_paddle_l_y  in  6  top row of the left paddle.
- i_paddle_r_y  in  6  top row of the right paddle.
- o_ball_enable  out  1  drives the ball enable; 0 holds the ball at centre.
- o_score_l  out  4  left player score.
- o_score_r  out  4  right player score.
- o_state  out  3  current FSM state, for the display.
- o_winner  out  1  0 = left won, 1 = right won; valid only in OVER.
- o_point  out  1  one-cycle pulse when a point is scored (sound hook).

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER.
- IDLE: ball disabled, scores held. i_start → clear both scores, go to SERVE.
- SERVE: ball disabled, tick counter loaded. Counter expiry → PLAY.
- PLAY: o_ball_enable=1. Every cycle, evaluate the two miss conditions below.
- Left miss:
  - Condition: i_ball_x==0 && i_ball_dir[0]==0 && !cover(i_paddle_l_y).
  - Action: o_score_r++, o_point=1, go to POINT.
- Right miss:
  - Condition: i_ball_x==GAME_WIDTH && i_ball_dir[0]==1 && !cover(i_paddle_r_y).
  - Action: o_score_l++, o_point=1, go to POINT.
- cover(p) is true when p ≤ i_ball_y ≤ p+PADDLE_H-1. Evaluate the sum 7 bits wide so it cannot wrap.
- A covered edge is a hit: no action; the ball bounces by itself.
- Both miss conditions cannot hold together, since x cannot be both 0 and GAME_WIDTH. If it ever happens, the left check wins.
- POINT: ball disabled, which recentres it, so the miss condition is counted exactly once.
  - If the incremented score == WIN_SCORE → OVER, with o_winner set to the scorer.
  - Otherwise → counter expiry → SERVE.
- OVER: ball disabled, scores frozen. i_start → clear scores, clear o_winner, go to SERVE.
- i_start is ignored in SERVE, PLAY and POINT.
- Scores saturate at 15. They cannot exceed WIN_SCORE in legal use.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, o_ball_enable=0, both scores 0, o_winner=0, o_point=0, counter 0.
- All outputs are registered, with 1-cycle latency from the triggering input.
- The i_start cycle is followed by SERVE on the next edge.
- SERVE lasts exactly SERVE_TICKS cycles; o_ball_enable rises on the following edge.
- A miss seen in PLAY at edge N gives: score, o_point and state=POINT at edge N+1, and o_ball_enable=0 at edge N+1.
- POINT lasts exactly POINT_TICKS cycles.
- Counter width is $clog2(max(SERVE_TICKS, POINT_TICKS)+1). It is loaded on state entry, decrements to 0, and expiry is taken at count 0.
- Reset asserted mid-rally forces IDLE within the same cycle (asynchronously) and drops the ball enable.

## Configuration
- PONG_SERVE_DELAY_EN defined: SERVE and POINT timing as above.
- PONG_SERVE_DELAY_EN undefined:
  - SERVE and POINT each last exactly 1 cycle.
  - The tick counter is not instantiated.
  - SERVE_TICKS and POINT_TICKS are ignored.
  - Scoring and winner logic are unchanged.

## Structure
- pong_pkg holds:
  - the state enum (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4);
  - direction bit constants (DIR_EAST_BIT=0, DIR_NORTH_BIT=1);
  - the score width (4).
- Ball, paddle and display blocks import pong_pkg for o_state decoding.
- One sub-module, pong_tick_timer: loadable down-counter with a done flag, instantiated only under PONG_SERVE_DELAY_EN.

## Test plan
Bench parameters: SERVE_TICKS=4, POINT_TICKS=3, WIN_SCORE=2, PADDLE_H=6.
- **Reset:** release reset, pulse i_start → SERVE for 4 cycles, then o_ball_enable=1 and state PLAY.
- **Hit:** x=0, dir=00, y=10, left paddle top=8 → no point; state stays PLAY; scores 0/0.
- **Left miss:** x=0, dir=00, y=20, left paddle top=8 → o_point pulses once; o_score_r=1; o_ball_enable=0 for 3 cycles, then SERVE.
- **Edge cover:** right paddle top=24, y=29, x=40, dir=01 → hit. Repeat with y=30 → o_score_l increments.
- **Match end:** two right misses → o_score_l=2, state OVER, o_winner=0. Later misses and extra i_start pulses mid-PLAY are ignored. i_start in OVER → scores 0/0, SERVE.
- **Reset mid-rally:** assert i_rst_n=0 in PLAY with scores 1/1 → immediately IDLE, scores 0/0, o_ball_enable=0.
